// File: rtl/instr_fetch_unit.sv
// Instruction fetch producer: issues word reads on the ibus and pushes
// 16/32-bit parcels into the fetch queue, tracking the fetch PC.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [1:0]  vacant_16bit_entry,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_gnt,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  output logic        q_in_req,
  output logic        q_in_16bit,
  output logic [31:0] q_in,
  output logic        q_clr,
  output logic [31:0] fetch_pc
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    PUSH
  } state_t;

  localparam logic [31:0] RST_PC = RESET_PC & 32'hFFFF_FFFE;

  state_t      state_q, state_d;
  logic        drop_q, drop_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        half_q;

  assign half_q    = pc_q[1];
  assign ibus_addr = addr_q;
  assign fetch_pc  = pc_q;
  assign q_clr     = redirect;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      pc_q    <= RST_PC;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ibus_req   = 1'b0;
    q_in_req   = 1'b0;
    q_in_16bit = 1'b0;
    q_in       = '0;
    unique case (state_q)
      IDLE: begin
        if (fetch_en && !redirect &&
            vacant_16bit_entry == 2'd2) begin
          state_d = REQ;
          addr_d  = {pc_q[31:2], 2'b00};
        end
      end
      REQ: begin
        ibus_req = 1'b1;
        if (redirect)
          drop_d = 1'b1;
        if (ibus_gnt)
          state_d = WAIT;
      end
      WAIT: begin
        if (ibus_rvalid) begin
          drop_d = 1'b0;
          if (drop_q || redirect) begin
            state_d = IDLE;
          end else begin
            data_d  = ibus_rdata;
            state_d = PUSH;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      PUSH: begin
        q_in_req   = !redirect;
        q_in_16bit = half_q;
        q_in       = half_q ? {16'h0, data_q[31:16]}
                            : data_q;
        if (!redirect)
          pc_d = pc_q + (half_q ? 32'd2 : 32'd4);
        state_d = IDLE;
      end
    endcase
    // a redirect always wins the PC, whatever the state
    if (redirect)
      pc_d = redirect_pc & 32'hFFFF_FFFE;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios then
// randomized traffic against an epoch-based reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rstn, fetch_en, redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  vac;
  logic        ibus_req, ibus_gnt, ibus_rvalid;
  logic [31:0] ibus_addr, ibus_rdata;
  logic        q_in_req, q_in_16bit, q_clr;
  logic [31:0] q_in, fetch_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk                (clk),
    .rstn               (rstn),
    .fetch_en           (fetch_en),
    .redirect           (redirect),
    .redirect_pc        (redirect_pc),
    .vacant_16bit_entry (vac),
    .ibus_req           (ibus_req),
    .ibus_addr          (ibus_addr),
    .ibus_gnt           (ibus_gnt),
    .ibus_rvalid        (ibus_rvalid),
    .ibus_rdata         (ibus_rdata),
    .q_in_req           (q_in_req),
    .q_in_16bit         (q_in_16bit),
    .q_in               (q_in),
    .q_clr              (q_clr),
    .fetch_pc           (fetch_pc)
  );

  int errors = 0;
  int checks = 0;

  // reference model: PC, redirect epochs, expected pushes
  logic [31:0] m_pc;
  logic [31:0] req_addr;
  logic [31:0] exp_data;
  int          epoch = 0;
  int          req_epoch = 0;
  int          pushes = 0;
  bit          req_active = 0;
  bit          exp_push = 0;
  bit          idle_prev = 1;
  bit          prev_ok = 0;
  bit          pushed = 0;

  // bus responder
  logic [31:0] pend_addr;
  bit          pend = 0;
  int          pend_cnt = 0;
  bit          hold_rv = 0;
  bit          fast = 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit started, want, nxt_push, idle_now;
    ibus_gnt    = ibus_req && (fast || $urandom_range(0, 2) == 0);
    ibus_rvalid = pend && pend_cnt == 0 && !hold_rv;
    ibus_rdata  = ibus_rvalid ? memf(pend_addr) : $urandom;
    @(negedge clk);
    chk("q_clr", 32'(q_clr), 32'(redirect));
    chk("fetch_pc", fetch_pc, m_pc);
    chk("one_outstanding", 32'(ibus_req && pend), 32'd0);
    started = ibus_req && !req_active;
    chk("req_start", 32'(started), 32'(idle_prev && prev_ok));
    if (started) begin
      req_active = 1;
      req_epoch  = epoch;
      req_addr   = ibus_addr;
      chk("req_addr", ibus_addr, {m_pc[31:2], 2'b00});
    end else if (ibus_req) begin
      chk("addr_hold", ibus_addr, req_addr);
    end
    want = exp_push && !redirect;
    chk("q_in_req", 32'(q_in_req), 32'(want));
    pushed = want;
    if (want) begin
      chk("q_in_16bit", 32'(q_in_16bit), 32'(m_pc[1]));
      chk("q_in", q_in,
          m_pc[1] ? {16'h0, exp_data[31:16]} : exp_data);
    end
    idle_now = !req_active && !exp_push;
    nxt_push = 0;
    if (ibus_rvalid && req_active) begin
      nxt_push   = (req_epoch == epoch) && !redirect;
      exp_data   = memf(req_addr);
      req_active = 0;
    end
    if (want) begin
      m_pc = m_pc + (m_pc[1] ? 32'd2 : 32'd4);
      pushes++;
    end
    if (redirect) begin
      m_pc = redirect_pc & 32'hFFFF_FFFE;
      epoch++;
    end
    prev_ok = fetch_en && !redirect && vac == 2'd2 && rstn;
    if (!rstn) begin
      m_pc       = RPC;
      req_active = 0;
      nxt_push   = 0;
      epoch++;
      prev_ok    = 0;
    end
    exp_push  = nxt_push;
    idle_prev = idle_now;
    @(posedge clk);
    if (ibus_rvalid) pend = 0;
    else if (pend && pend_cnt > 0) pend_cnt--;
    if (ibus_gnt) begin
      pend      = 1;
      pend_addr = ibus_addr;
      pend_cnt  = fast ? 0 : $urandom_range(0, 3);
    end
    #1;
    redirect = 1'b0;
  endtask

  task automatic run_until_push(input int max, input string tag);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!pushed && n < max);
    chk(tag, 32'(pushed), 32'd1);
  endtask

  task automatic run_until_pend(input int max, input string tag);
    int n = 0;
    while (!pend && n < max) begin
      cycle();
      n++;
    end
    chk(tag, 32'(pend), 32'd1);
  endtask

  initial begin
    int p0;
    rstn        = 1'b0;
    fetch_en    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    vac         = 2'd2;
    ibus_gnt    = 1'b0;
    ibus_rvalid = 1'b0;
    ibus_rdata  = '0;
    m_pc        = RPC;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("rst_fetch_pc", fetch_pc, RPC);
    chk("rst_ibus_req", 32'(ibus_req), 32'd0);
    chk("rst_q_in_req", 32'(q_in_req), 32'd0);
    chk("rst_q_in_16bit", 32'(q_in_16bit), 32'd0);
    chk("rst_q_in", q_in, 32'd0);

    // first word at reset PC
    fetch_en = 1'b1;
    run_until_push(10, "push0_timeout");
    chk("pc_after_first", fetch_pc, 32'h104);

    // halfword-aligned redirect
    redirect    = 1'b1;
    redirect_pc = 32'h202;
    cycle();
    run_until_push(10, "push_half_timeout");
    chk("pc_after_half", fetch_pc, 32'h204);
    run_until_push(10, "push_word_timeout");
    chk("pc_after_word", fetch_pc, 32'h208);

    // vacancy throttle
    vac = 2'd1;
    repeat (6) begin
      cycle();
      chk("throttle_req", 32'(ibus_req), 32'd0);
    end
    vac = 2'd2;
    cycle();
    chk("vac_release_req", 32'(ibus_req), 32'd1);
    run_until_push(10, "push_vac_timeout");

    // redirect while waiting for data
    hold_rv = 1;
    run_until_pend(10, "wait_pend_timeout");
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    cycle();
    hold_rv  = 0;
    fetch_en = 1'b0;
    p0 = pushes;
    repeat (4) cycle();
    chk("dropped_no_push", 32'(pushes), 32'(p0));
    fetch_en = 1'b1;
    run_until_push(10, "push_after_drop_timeout");
    chk("pc_after_drop", fetch_pc, 32'h404);

    // redirect coinciding with PUSH
    begin
      int n = 0;
      while (!exp_push && n < 20) begin
        cycle();
        n++;
      end
      chk("reach_push_timeout", 32'(exp_push), 32'd1);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h500;
    cycle();
    chk("pc_push_redirect", fetch_pc, 32'h500);

    // PC wrap
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    run_until_push(10, "push_wrap_timeout");
    chk("pc_wrap", fetch_pc, 32'h0);

    // sync reset while in WAIT, late response ignored
    hold_rv = 1;
    run_until_pend(10, "rst_pend_timeout");
    fetch_en = 1'b0;
    rstn     = 1'b0;
    cycle();
    rstn = 1'b1;
    chk("pc_after_rst", fetch_pc, RPC);
    hold_rv = 0;
    p0 = pushes;
    repeat (4) cycle();
    chk("late_rvalid_no_push", 32'(pushes), 32'(p0));
    chk("late_rvalid_idle", 32'(ibus_req), 32'd0);

    // randomized traffic
    fast = 0;
    for (int i = 0; i < 600; i++) begin
      fetch_en = ($urandom_range(0, 9) < 8);
      vac      = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 11) == 0) begin
        redirect    = 1'b1;
        redirect_pc = $urandom;
      end
      cycle();
    end
    chk("random_progress", 32'(pushes > 20), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
